intc_apb: RTL

Parametrised APB interrupt controller and system timer: the successor of the single-timer, single-bus-error interrupt block. It aggregates the APB bus-error line, an internal programmable timer and `NUM_SRC` external interrupt sources into one CPU interrupt. Each source has a pending bit, an enable bit and a level/edge mode. A claim register returns the highest-priority source. It sits on the APB fabric at `BASE_ADDR` and drives the core's `cpu_interrupt` input.

---
 rtl/intc_pkg.sv | 33 +++
 rtl/intc_timer.sv | 78 +++++++
 rtl/intc_apb.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/intc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : intc_pkg
//  Purpose  : Shared constants for the APB interrupt controller: register
//             word offsets, pending-bit indices and TIMER_CTRL field positions.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package intc_pkg;

   // Register word offsets inside the 64-byte window
   localparam logic [5:0] OFF_PENDING = 6'h00;
   localparam logic [5:0] OFF_ENABLE  = 6'h04;
   localparam logic [5:0] OFF_MODE    = 6'h08;
   localparam logic [5:0] OFF_CLAIM   = 6'h0C;
   localparam logic [5:0] OFF_TCMP    = 6'h10;
   localparam logic [5:0] OFF_TCNT    = 6'h14;
   localparam logic [5:0] OFF_TCTRL   = 6'h18;

   // Size of the decoded register window in bytes
   localparam int unsigned WIN_BYTES = 64;

   // Pending bit map
   localparam int PEND_BUSERR = 0;
   localparam int PEND_TIMER  = 1;
   localparam int PEND_EXT0   = 2;

   // TIMER_CTRL fields
   localparam int TCTRL_EN = 0;
   localparam int TCTRL_AR = 1;

endpackage
`default_nettype wire

// File: rtl/intc_timer.sv
`default_nettype none
// ============================================================================
//  Module   : intc_timer
//  Purpose  : Programmable system timer. Counts up while enabled; on reaching
//             the compare value it flags a match and either reloads to zero
//             (autoreload) or holds and disables itself.
//  Ports    : pclk/presetn      - clock, async active-low reset
//             *_we / *_wdata    - register write ports (data already merged
//                                 with byte strobes by the bus front end)
//             cmp, cnt, ctrl    - current register contents
//             match             - counter equals compare while enabled
//  Revision : 1.0 - initial release
// ============================================================================
module intc_timer
   import intc_pkg::*;
#(
   parameter int                     TIMER_WIDTH = 32,
   parameter logic [TIMER_WIDTH-1:0] RST_CMP     = 'h10000
) (
   input  logic                   pclk,
   input  logic                   presetn,
   input  logic                   cmp_we,
   input  logic                   cnt_we,
   input  logic                   ctrl_we,
   input  logic [TIMER_WIDTH-1:0] cmp_wdata,
   input  logic [TIMER_WIDTH-1:0] cnt_wdata,
   input  logic [1:0]             ctrl_wdata,
   output logic [TIMER_WIDTH-1:0] cmp,
   output logic [TIMER_WIDTH-1:0] cnt,
   output logic [1:0]             ctrl,
   output logic                   match
);

   logic [TIMER_WIDTH-1:0] r_cmp;
   logic [TIMER_WIDTH-1:0] r_cnt;
   logic [1:0]             r_ctrl;
   logic                   w_match;

   // A disabled timer never matches, otherwise a one-shot that has already
   // stopped on its compare value would keep re-firing.
   assign w_match = r_ctrl[TCTRL_EN] && (r_cnt == r_cmp);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_cmp  <= RST_CMP;
         r_cnt  <= '0;
         r_ctrl <= 2'b11;
      end else begin
         if (cmp_we) begin
            r_cmp <= cmp_wdata;
         end

         // Software writes take priority over counting and reloading
         if (cnt_we) begin
            r_cnt <= cnt_wdata;
         end else if (w_match) begin
            if (r_ctrl[TCTRL_AR]) begin
               r_cnt <= '0;
            end
         end else if (r_ctrl[TCTRL_EN]) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (ctrl_we) begin
            r_ctrl <= ctrl_wdata;
         end else if (w_match && !r_ctrl[TCTRL_AR]) begin
            r_ctrl[TCTRL_EN] <= 1'b0;
         end
      end
   end

   assign cmp   = r_cmp;
   assign cnt   = r_cnt;
   assign ctrl  = r_ctrl;
   assign match = w_match;

endmodule
`default_nettype wire

// File: rtl/intc_apb.sv
`default_nettype none
// ============================================================================
//  Module   : intc_apb
//  Purpose  : APB interrupt controller and system timer. Aggregates the bus
//             error event, the internal timer and NUM_SRC external sources
//             into a single registered CPU interrupt, with per-source pending,
//             enable and level/edge mode, plus a priority claim register.
//  Ports    : pclk, presetn                - clock, async active-low reset
//             paddr, pdata, pstb           - APB address, write data, strobes
//             psel, penable, pwrite        - APB control
//             prdata, pready, perr         - APB response (one wait state)
//             irq_src                      - external sources, active-high
//             APB_perr                     - fabric bus-error event
//             cpu_interrupt                - OR of pending & enabled, registered
//  Revision : 1.0 - initial release
// ============================================================================
module intc_apb
   import intc_pkg::*;
#(
   parameter int                     ADDR_WIDTH    = 32,
   parameter int                     DATA_WIDTH    = 32,
   parameter int                     NUM_SRC       = 8,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR     = 32'h2000_0000,
   parameter int                     TIMER_WIDTH   = 32,
   parameter logic [TIMER_WIDTH-1:0] TIMER_RST_CMP = 'h10000
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pdata,
   output logic [DATA_WIDTH-1:0] prdata,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [3:0]            pstb,
   output logic                  pready,
   output logic                  perr,
   input  logic [NUM_SRC-1:0]    irq_src,
   input  logic                  APB_perr,
   output logic                  cpu_interrupt
);

   // Pending/enable vector width: bus error, timer, then the external sources
   localparam int NP = NUM_SRC + PEND_EXT0;

   logic                   r_pready;
   logic                   r_perr;
   logic [DATA_WIDTH-1:0]  r_prdata;
   logic                   r_cpu_int;
   logic [NP-1:0]          r_pend;
   logic [NP-1:0]          r_enable;
   logic [NUM_SRC-1:0]     r_mode;
   logic [NUM_SRC-1:0]     r_irq_q;
   logic [NUM_SRC-1:0]     r_irq_q2;

   logic [ADDR_WIDTH-1:0]  w_off;
   logic [5:0]             w_reg;
   logic                   w_valid;
   logic                   w_access;
   logic                   w_wr;
   logic                   w_rd;
   logic [DATA_WIDTH-1:0]  w_mask;
   logic [DATA_WIDTH-1:0]  w_rdata;
   logic [DATA_WIDTH-1:0]  w_claim_id;
   logic [NP-1:0]          w_claim_oh;
   logic [NP-1:0]          w_sticky;
   logic [NP-1:0]          w_pend;
   logic [NP-1:0]          w_act;
   logic [NP-1:0]          w_set;
   logic [NP-1:0]          w_clr;
   logic [NP-1:0]          w_enable_nx;
   logic [NUM_SRC-1:0]     w_mode_nx;

   logic                   w_tmatch;
   logic [TIMER_WIDTH-1:0] w_tcmp;
   logic [TIMER_WIDTH-1:0] w_tcnt;
   logic [1:0]             w_tctrl;
   logic [TIMER_WIDTH-1:0] w_tcmp_wd;
   logic [TIMER_WIDTH-1:0] w_tcnt_wd;
   logic [1:0]             w_tctrl_wd;

   // ------------------------------------------------------------------------
   // Address decode and APB handshake
   // ------------------------------------------------------------------------
   assign w_off    = paddr - BASE_ADDR;
   assign w_reg    = w_off[5:0];
   assign w_access = psel & penable & ~r_pready;
   assign w_wr     = w_access &  pwrite & w_valid;
   assign w_rd     = w_access & ~pwrite & w_valid;

   always_comb begin
      w_valid = 1'b0;
      if (w_off < ADDR_WIDTH'(WIN_BYTES)) begin
         case (w_reg)
            OFF_PENDING, OFF_ENABLE, OFF_MODE, OFF_CLAIM,
            OFF_TCMP, OFF_TCNT, OFF_TCTRL: w_valid = 1'b1;
            default:                       w_valid = 1'b0;
         endcase
      end
   end

   // Byte-lane write mask; lanes beyond the four strobes are never written
   always_comb begin
      w_mask = '0;
      for (int j = 0; j < DATA_WIDTH; j++) begin
         w_mask[j] = (j < 32) ? pstb[(j >> 3) & 3] : 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Pending state
   // ------------------------------------------------------------------------
   // Bus error and timer are always sticky; external bits follow MODE.
   assign w_sticky = {r_mode, 2'b11};
   // Level-mode bits read the live source; only sticky bits hold state.
   assign w_pend   = (r_pend & w_sticky) | ({irq_src, 2'b00} & ~w_sticky);
   assign w_act    = w_pend & r_enable;

   // Priority encoder: the lowest-numbered active bit wins
   always_comb begin
      w_claim_id = '0;
      w_claim_oh = '0;
      for (int n = NP - 1; n >= 0; n--) begin
         if (w_act[n]) begin
            w_claim_id    = DATA_WIDTH'(n + 1);
            w_claim_oh    = '0;
            w_claim_oh[n] = 1'b1;
         end
      end
   end

   always_comb begin
      w_set                    = '0;
      w_set[PEND_BUSERR]       = APB_perr;
      w_set[PEND_TIMER]        = w_tmatch;
      w_set[NP-1:PEND_EXT0]    = r_mode & r_irq_q & ~r_irq_q2;

      w_clr = '0;
      if (w_wr && (w_reg == OFF_PENDING)) begin
         w_clr = pdata[NP-1:0] & w_mask[NP-1:0];
      end
      if (w_rd && (w_reg == OFF_CLAIM)) begin
         w_clr = w_clr | w_claim_oh;
      end
   end

   assign w_enable_nx = (r_enable & ~w_mask[NP-1:0]) | (pdata[NP-1:0] & w_mask[NP-1:0]);
   assign w_mode_nx   = (r_mode & ~w_mask[NP-1:PEND_EXT0]) |
                        (pdata[NP-1:PEND_EXT0] & w_mask[NP-1:PEND_EXT0]);

   // ------------------------------------------------------------------------
   // Timer
   // ------------------------------------------------------------------------
   assign w_tcmp_wd  = (w_tcmp & ~w_mask[TIMER_WIDTH-1:0]) |
                       (pdata[TIMER_WIDTH-1:0] & w_mask[TIMER_WIDTH-1:0]);
   assign w_tcnt_wd  = (w_tcnt & ~w_mask[TIMER_WIDTH-1:0]) |
                       (pdata[TIMER_WIDTH-1:0] & w_mask[TIMER_WIDTH-1:0]);
   assign w_tctrl_wd = (w_tctrl & ~w_mask[1:0]) | (pdata[1:0] & w_mask[1:0]);

   intc_timer #(
      .TIMER_WIDTH (TIMER_WIDTH),
      .RST_CMP     (TIMER_RST_CMP)
   ) u_timer (
      .pclk        (pclk),
      .presetn     (presetn),
      .cmp_we      (w_wr && (w_reg == OFF_TCMP)),
      .cnt_we      (w_wr && (w_reg == OFF_TCNT)),
      .ctrl_we     (w_wr && (w_reg == OFF_TCTRL)),
      .cmp_wdata   (w_tcmp_wd),
      .cnt_wdata   (w_tcnt_wd),
      .ctrl_wdata  (w_tctrl_wd),
      .cmp         (w_tcmp),
      .cnt         (w_tcnt),
      .ctrl        (w_tctrl),
      .match       (w_tmatch)
   );

   // ------------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------------
   always_comb begin
      w_rdata = '0;
      case (w_reg)
         OFF_PENDING: w_rdata = DATA_WIDTH'(w_pend);
         OFF_ENABLE:  w_rdata = DATA_WIDTH'(r_enable);
         OFF_MODE:    w_rdata = DATA_WIDTH'({r_mode, 2'b00});
         OFF_CLAIM:   w_rdata = w_claim_id;
         OFF_TCMP:    w_rdata = DATA_WIDTH'(w_tcmp);
         OFF_TCNT:    w_rdata = DATA_WIDTH'(w_tcnt);
         OFF_TCTRL:   w_rdata = DATA_WIDTH'(w_tctrl);
         default:     w_rdata = '0;
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_pready  <= 1'b0;
         r_perr    <= 1'b0;
         r_prdata  <= '0;
         r_cpu_int <= 1'b0;
         r_pend    <= '0;
         r_enable  <= NP'(2'b11);
         r_mode    <= '0;
         r_irq_q   <= '0;
         r_irq_q2  <= '0;
      end else begin
         r_pready  <= w_access;
         r_perr    <= w_access & ~w_valid;
         r_prdata  <= w_rd ? w_rdata : '0;
         r_irq_q   <= irq_src;
         r_irq_q2  <= r_irq_q;
         // Hardware set is applied after the clear so that it wins
         r_pend    <= ((r_pend & ~w_clr) | w_set) & w_sticky;
         r_cpu_int <= |w_act;
         if (w_wr && (w_reg == OFF_ENABLE)) begin
            r_enable <= w_enable_nx;
         end
         if (w_wr && (w_reg == OFF_MODE)) begin
            r_mode <= w_mode_nx;
         end
      end
   end

   assign prdata        = r_prdata;
   assign pready        = r_pready;
   assign perr          = r_perr;
   assign cpu_interrupt = r_cpu_int;

endmodule
`default_nettype wire
